// File: rtl/usb_uart_pkg.sv
// Shared definitions for the Wishbone UART polling controller: register map,
// STATUS bit positions and the controller state encoding.
package usb_uart_pkg;

   localparam logic [3:0] REG_TX     = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h4;
   localparam logic [3:0] REG_RX     = 4'h8;

   localparam int STATUS_TXRDY = 0;
   localparam int STATUS_RXVLD = 1;

   typedef enum logic [1:0] {
      POLL  = 2'd0,
      RD_RX = 2'd1,
      WR_TX = 2'd2,
      WAIT  = 2'd3
   } state_t;

   typedef enum logic {
      SRV_RX = 1'b0,
      SRV_TX = 1'b1
   } served_t;

   function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [3:0] offset);
      return base + {28'h0, offset};
   endfunction

endpackage

// File: rtl/wb_uart_poll_ctrl_byte_hold_reg.sv
// One-entry byte holding register with a valid flag; used for both the TX
// and the RX path of the UART polling controller.
module byte_hold_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       clear,
   output logic       valid,
   output logic [7:0] data
);

   logic       valid_reg;
   logic [7:0] data_reg;

   // Data is kept after clear so a consumer may still look at the last byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= 8'h00;
      end else if (load) begin
         valid_reg <= 1'b1;
         data_reg  <= load_data;
      end else if (clear) begin
         valid_reg <= 1'b0;
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;

endmodule

// File: rtl/wb_uart_poll_ctrl.sv
// Wishbone master that polls a UART, drains RX bytes to a stream and writes
// queued TX bytes. Optional bus timeout: define USB_UART_POLL_TIMEOUT_EN.
module wb_uart_poll_ctrl
   import usb_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0,
   parameter int          POLL_DIV       = 16,
   parameter int          TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic        wbm_we_o,
   output logic        wbm_stb_o,
   output logic        wbm_cyc_o,
   input  logic        wbm_ack_i,
   input  logic [7:0]  s_tx_tdata,
   input  logic        s_tx_tvalid,
   output logic        s_tx_tready,
   output logic [7:0]  m_rx_tdata,
   output logic        m_rx_tvalid,
   input  logic        m_rx_tready,
   output logic        busy_o
`ifdef USB_UART_POLL_TIMEOUT_EN
   ,
   output logic        timeout_o
`endif
);

   // One counter width serves both the poll divider and the bus timeout.
   localparam int CNT_MAX = (POLL_DIV > TIMEOUT_CYCLES) ? POLL_DIV : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(POLL_DIV - 1);

   state_t            state_reg, state_next;
   served_t           last_served_reg, last_served_next;
   logic              stb_reg, stb_next;
   logic [31:0]       adr_reg, adr_next;
   logic [31:0]       dat_reg, dat_next;
   logic              we_reg, we_next;
   logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
   logic              busy_reg;

   logic              tx_valid;
   logic [7:0]        tx_data;
   logic              tx_load, tx_clear;
   logic              rx_load, rx_clear;
   logic              can_rx, can_tx;
   logic              unused_bits;

   assign unused_bits = ^wbm_dat_i[31:8];

   assign tx_load     = s_tx_tvalid & ~tx_valid;
   assign s_tx_tready = ~tx_valid;
   assign rx_clear    = m_rx_tvalid & m_rx_tready;

   byte_hold_reg u_tx_hold (
      .clk       (clk),
      .rst       (rst),
      .load      (tx_load),
      .load_data (s_tx_tdata),
      .clear     (tx_clear),
      .valid     (tx_valid),
      .data      (tx_data)
   );

   byte_hold_reg u_rx_hold (
      .clk       (clk),
      .rst       (rst),
      .load      (rx_load),
      .load_data (wbm_dat_i[7:0]),
      .clear     (rx_clear),
      .valid     (m_rx_tvalid),
      .data      (m_rx_tdata)
   );

   // Decision inputs are only meaningful in the POLL ack cycle.
   assign can_rx = wbm_dat_i[STATUS_RXVLD] & ~m_rx_tvalid;
   assign can_tx = wbm_dat_i[STATUS_TXRDY] & tx_valid;

`ifdef USB_UART_POLL_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] to_cnt_reg;
   logic             timeout_fire;
   logic             timeout_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_reg  <= '0;
         timeout_reg <= 1'b0;
      end else begin
         timeout_reg <= timeout_fire;
         to_cnt_reg  <= stb_reg ? to_cnt_reg + 1'b1 : '0;
      end
   end

   assign timeout_o = timeout_reg;
`endif

   always_comb begin
      state_next       = state_reg;
      last_served_next = last_served_reg;
      stb_next         = stb_reg;
      adr_next         = adr_reg;
      we_next          = we_reg;
      dat_next         = dat_reg;
      wait_cnt_next    = wait_cnt_reg;
      tx_clear         = 1'b0;
      rx_load          = 1'b0;
`ifdef USB_UART_POLL_TIMEOUT_EN
      timeout_fire     = 1'b0;
`endif

      // Each bus state spends one idle cycle with stb low before launching.
      case (state_reg)
         POLL: begin
            if (!stb_reg) begin
               stb_next = 1'b1;
               adr_next = reg_addr(BASE_ADDR, REG_STATUS);
               we_next  = 1'b0;
               dat_next = 32'h0;
            end else if (wbm_ack_i) begin
               stb_next = 1'b0;
               if (can_rx && can_tx) begin
                  state_next = (last_served_reg == SRV_TX) ? RD_RX : WR_TX;
               end else if (can_rx) begin
                  state_next = RD_RX;
               end else if (can_tx) begin
                  state_next = WR_TX;
               end else begin
                  state_next    = WAIT;
                  wait_cnt_next = '0;
               end
            end
         end
         RD_RX: begin
            if (!stb_reg) begin
               stb_next = 1'b1;
               adr_next = reg_addr(BASE_ADDR, REG_RX);
               we_next  = 1'b0;
               dat_next = 32'h0;
            end else if (wbm_ack_i) begin
               stb_next         = 1'b0;
               rx_load          = 1'b1;
               last_served_next = SRV_RX;
               state_next       = POLL;
            end
         end
         WR_TX: begin
            if (!stb_reg) begin
               stb_next = 1'b1;
               adr_next = reg_addr(BASE_ADDR, REG_TX);
               we_next  = 1'b1;
               dat_next = {24'h0, tx_data};
            end else if (wbm_ack_i) begin
               stb_next         = 1'b0;
               tx_clear         = 1'b1;
               last_served_next = SRV_TX;
               state_next       = POLL;
            end
         end
         WAIT: begin
            // New stream activity means there may be work: re-poll at once.
            if (tx_load || rx_clear || wait_cnt_reg == WAIT_LAST) begin
               state_next = POLL;
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
         end
         default: state_next = POLL;
      endcase

`ifdef USB_UART_POLL_TIMEOUT_EN
      // Abort leaves both holding registers untouched so TX is retried.
      if (stb_reg && !wbm_ack_i && to_cnt_reg == TO_LAST) begin
         stb_next      = 1'b0;
         state_next    = WAIT;
         wait_cnt_next = '0;
         timeout_fire  = 1'b1;
         rx_load       = 1'b0;
         tx_clear      = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= POLL;
         last_served_reg <= SRV_TX;
         stb_reg         <= 1'b0;
         adr_reg         <= 32'h0;
         we_reg          <= 1'b0;
         dat_reg         <= 32'h0;
         wait_cnt_reg    <= '0;
         busy_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         last_served_reg <= last_served_next;
         stb_reg         <= stb_next;
         adr_reg         <= adr_next;
         we_reg          <= we_next;
         dat_reg         <= dat_next;
         wait_cnt_reg    <= wait_cnt_next;
         busy_reg        <= (state_next != WAIT);
      end
   end

   assign wbm_adr_o = adr_reg;
   assign wbm_dat_o = dat_reg;
   assign wbm_we_o  = we_reg;
   assign wbm_stb_o = stb_reg;
   assign wbm_cyc_o = stb_reg;
   assign busy_o    = busy_reg;

endmodule
